// File: rtl/serial_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared definitions for the serial deserialiser slice:
//                receiver FSM state encoding, serial line level constants
//                and the even-parity check helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  // Receiver FSM state encoding. PARITY is only reachable in the parity build.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Serial line levels.
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity: data bits plus parity bit must XOR to zero. Data is passed
  // zero-extended to 16 bits (the widest legal word), which does not change
  // the XOR reduction.
  function automatic logic parity_mismatch(input logic [15:0] data,
                                           input logic        pbit);
    return (^data) ^ pbit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_deser_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_deser_rx_if
//  Description : Ready/valid word output bus of the serial receiver.
//                master : drives out_data / out_valid, samples out_ready
//                slave  : samples out_data / out_valid, drives out_ready
//  Ports       : out_data  [DATA_W] word at FIFO head
//                out_valid         out_data holds a valid word
//                out_ready         consumer accepts the word (pop on both high)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_deser_rx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/serial_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_fifo
//  Description : First-word-fall-through FIFO for received words.
//                A push into a full FIFO is accepted only when a pop occurs
//                in the same cycle; a pop from an empty FIFO is ignored.
//  Ports       : clk, reset_n         clock, async active-low reset
//                push, wdata[WIDTH]   write request and data
//                pop                  read request (head is removed)
//                rdata[WIDTH]         head word, 0 while empty
//                full, empty          status
//                level[log2(DEPTH)+1] words held, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     reset_n,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         wdata,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign level = r_count;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  // Gating the head with empty keeps out_data at 0 after reset and between
  // words, without needing to reset the storage array.
  assign rdata = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_deser_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_deser_rx
//  Description : Serial frame receiver, one bit per clk (no oversampling).
//                Frame: start(0), DATA_W data bits LSB first, optional even
//                parity bit, stop(1). Good words go into a FWFT FIFO.
//  Config      : SERIAL_DESER_RX_PARITY_EN defined   -> parity bit present
//                SERIAL_DESER_RX_PARITY_EN undefined -> no parity bit,
//                                                       parity_err tied 0
//  Ports       : clk, reset_n      clock, async active-low reset
//                serial_in         serial line, idle high
//                rx_bus (master)   out_data / out_valid / out_ready
//                frame_err         1-cycle pulse, stop bit sampled low
//                parity_err        1-cycle pulse, parity mismatch
//                overrun           1-cycle pulse, word dropped, FIFO full
//                fill_level        words currently held
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_deser_rx
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                          clk,
  input  wire logic                          reset_n,
  input  wire logic                          serial_in,
  serial_deser_rx_if.master                  rx_bus,
  output logic                               frame_err,
  output logic                               parity_err,
  output logic                               overrun,
  output logic [$clog2(FIFO_DEPTH):0]        fill_level
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] C_LAST_BIT = CW'(DATA_W - 1);

  localparam logic [1:0] C_ST_IDLE   = IDLE;
  localparam logic [1:0] C_ST_DATA   = DATA;
  localparam logic [1:0] C_ST_PARITY = PARITY;
  localparam logic [1:0] C_ST_STOP   = STOP;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_frame_err;
  logic              r_overrun;

  logic              w_perr;
  logic              w_stop_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;

  // --------------------------------------------------------------------------
  // Optional parity: pending error flag, its output pulse
  // --------------------------------------------------------------------------
`ifdef SERIAL_DESER_RX_PARITY_EN
  logic r_perr;
  logic r_parity_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perr       <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if (r_state == C_ST_IDLE) begin
        r_perr <= 1'b0;
      end else if (r_state == C_ST_PARITY) begin
        r_perr <= parity_mismatch(16'(r_shift), serial_in);
      end else if (r_state == C_ST_STOP) begin
        // A low stop bit is reported as a framing error only.
        r_parity_err <= (serial_in == STOP_BIT) & r_perr;
        r_perr       <= 1'b0;
      end
    end
  end

  assign w_perr     = r_perr;
  assign parity_err = r_parity_err;
`else
  assign w_perr     = 1'b0;
  assign parity_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FIFO interface
  // --------------------------------------------------------------------------
  assign w_stop_ok = (r_state == C_ST_STOP) && (serial_in == STOP_BIT);
  assign w_push    = w_stop_ok & ~w_perr;
  assign w_pop     = ~w_empty & rx_bus.out_ready;

  serial_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .wdata   (r_shift),
    .pop     (w_pop),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fill_level)
  );

  assign rx_bus.out_data  = w_head;
  assign rx_bus.out_valid = ~w_empty;
  assign frame_err        = r_frame_err;
  assign overrun          = r_overrun;

  // --------------------------------------------------------------------------
  // Receiver FSM, bit counter and shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= C_ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (serial_in == START_BIT) begin
            r_state   <= C_ST_DATA;
            r_bit_cnt <= '0;
          end
        end

        C_ST_DATA: begin
          r_shift[r_bit_cnt] <= serial_in;
          if (r_bit_cnt == C_LAST_BIT) begin
`ifdef SERIAL_DESER_RX_PARITY_EN
            r_state <= C_ST_PARITY;
`else
            r_state <= C_ST_STOP;
`endif
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

`ifdef SERIAL_DESER_RX_PARITY_EN
        C_ST_PARITY: begin
          r_state <= C_ST_STOP;
        end
`endif

        C_ST_STOP: begin
          // Always back to IDLE: a low stop bit is never taken as the next
          // start bit.
          r_state <= C_ST_IDLE;
          if (serial_in != STOP_BIT) begin
            r_frame_err <= 1'b1;
          end else if (!w_perr && w_full && !w_pop) begin
            // Full with a simultaneous pop is a normal push, not an overrun.
            r_overrun <= 1'b1;
          end
        end

        default: begin
          r_state <= C_ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_deser_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_serial_deser_rx
//  Description : Directed, table-driven bench for serial_deser_rx
//                (DATA_W=8, FIFO_DEPTH=4). Follows the
//                SERIAL_DESER_RX_PARITY_EN setting of the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_deser_rx;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       serial_in = 1'b1;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic [2:0] fill_level;

  serial_deser_rx_if #(.DATA_W(DATA_W)) bus ();

  serial_deser_rx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .serial_in  (serial_in),
    .rx_bus     (bus),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold one bit across one rising edge; returns 1 time unit after the edge.
  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // Send one frame. flip inverts the correct parity bit (parity build only).
  // pop_at_stop raises out_ready only for the stop-bit edge.
  task automatic send_frame(input logic [7:0] w, input logic stop,
                            input logic flip, input logic pop_at_stop);
    logic pbit;
    pbit = (^w) ^ flip;
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(w[i]);
`ifdef SERIAL_DESER_RX_PARITY_EN
    send_bit(pbit);
`endif
    if (pop_at_stop) bus.out_ready = 1'b1;
    send_bit(stop);
    if (pop_at_stop) bus.out_ready = 1'b0;
  endtask

  task automatic drain(input logic [7:0] first, input int n);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", 32'(bus.out_valid), 32'd1);
      check("drain_data", 32'(bus.out_data), 32'(first + 8'(i)));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    check("drain_empty_valid", 32'(bus.out_valid), 32'd0);
    check("drain_empty_fill", 32'(fill_level), 32'd0);
  endtask

  typedef struct {
    logic [7:0] word;
    logic       stop;
    logic       flip;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // word, stop, flip, exp_valid, exp_frame_err, exp_parity_err
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef SERIAL_DESER_RX_PARITY_EN
    vecs.push_back('{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
`endif

    bus.out_ready = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);

    // Table: one frame each, consumer always ready
    bus.out_ready = 1'b1;
    foreach (vecs[k]) begin
      send_frame(vecs[k].word, vecs[k].stop, vecs[k].flip, 1'b0);
      check("vec_valid", 32'(bus.out_valid), 32'(vecs[k].exp_valid));
      if (vecs[k].exp_valid)
        check("vec_data", 32'(bus.out_data), 32'(vecs[k].word));
      check("vec_ferr", 32'(frame_err), 32'(vecs[k].exp_ferr));
      check("vec_perr", 32'(parity_err), 32'(vecs[k].exp_perr));
      check("vec_fill", 32'(fill_level), 32'(vecs[k].exp_valid));
      check("vec_ovr", 32'(overrun), 32'd0);
      send_bit(1'b1);
      check("vec_ferr_end", 32'(frame_err), 32'd0);
      check("vec_perr_end", 32'(parity_err), 32'd0);
      check("vec_valid_end", 32'(bus.out_valid), 32'd0);
      check("vec_fill_end", 32'(fill_level), 32'd0);
    end
    bus.out_ready = 1'b0;

    // Five back-to-back frames into a 4-deep FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
      if (i == 0) check("b2b_fill1", 32'(fill_level), 32'd1);
      if (i == 3) begin
        check("b2b_fill4", 32'(fill_level), 32'd4);
        check("b2b_no_ovr", 32'(overrun), 32'd0);
      end
      if (i == 4) begin
        check("b2b_ovr", 32'(overrun), 32'd1);
        check("b2b_fill_sat", 32'(fill_level), 32'd4);
      end
    end
    send_bit(1'b1);
    check("b2b_ovr_end", 32'(overrun), 32'd0);
    check("b2b_stable", 32'(bus.out_data), 32'h10);
    drain(8'h10, 4);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
    check("fp_fill4", 32'(fill_level), 32'd4);
    send_frame(8'h24, 1'b1, 1'b0, 1'b1);
    check("fp_no_ovr", 32'(overrun), 32'd0);
    check("fp_fill", 32'(fill_level), 32'd4);
    check("fp_head", 32'(bus.out_data), 32'h21);
    send_bit(1'b1);
    check("fp_no_ovr2", 32'(overrun), 32'd0);
    drain(8'h21, 4);

    // Reset in the middle of a frame
    send_frame(8'h77, 1'b1, 1'b0, 1'b0);
    check("mr_pre_fill", 32'(fill_level), 32'd1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    serial_in = 1'b1;
    reset_n   = 1'b0;
    #2;
    check("mr_async_valid", 32'(bus.out_valid), 32'd0);
    check("mr_async_fill", 32'(fill_level), 32'd0);
    check("mr_async_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    check("mr_no_partial", 32'(bus.out_valid), 32'd0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    check("mr_valid", 32'(bus.out_valid), 32'd1);
    check("mr_data", 32'(bus.out_data), 32'hFF);
    check("mr_fill", 32'(fill_level), 32'd1);
    drain(8'hFF, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
